light_phase_monitor: RTL and testbench
======================================

Name: light_phase_monitor

Overview:
- Safety monitor on the receiving end of the traffic controller's light bus.
- Samples the eight 3-bit lamp outputs T1..T8 every clock and checks lamp encoding, colour sequence, concurrency and dwell times.
- On any violation it latches a fault and drives `stop` back to the controller, freezing the sequence until software clears the fault.

Parameters:
- CW, 8, width of each per-lamp dwell counter; counters saturate at 2^CW-1.
- MIN_YELLOW, 3, minimum number of sampled cycles a lamp must stay yellow before going red.
- MAX_GREEN, 40, a lamp green for this many consecutive samples is a timeout fault.
- MAX_ACTIVE, 2, maximum number of lamps that may be non-red in the same sample.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- T1..T8  input  3 each  lamp states from the controller: bit2=red, bit1=yellow, bit0=green.
- clear  input  1  single-cycle pulse; acknowledges a latched fault.
- stop  output  1  freeze request to the controller.
- fault  output  1  fault latched.
- fault_code  output  3  cause of the latched fault; 0 = none.
- fault_light  output  3  index of the offending lamp, 0 = T1 .. 7 = T8.
- armed  output  1  monitor is actively checking.

Behaviour:
- Reset (synchronous, active-high): state=ARM, stop=0, fault=0, fault_code=0, fault_light=0, armed=0, all dwell counters=0, all prev registers=3'b100. Reset wins over every other input, including mid-FAULT.
- Legal encodings are 100 (R), 010 (Y) and 001 (G); anything else is illegal.
- Legal transitions are hold, R->G, G->Y and Y->R.
- State ARM:
  - armed=0; no checks are performed.
  - When all eight inputs are legal at an edge: load prev<=T, set counters to 1, go to MONITOR.
- State MONITOR:
  - armed=1.
  - Each edge, each lamp is compared against its prev value:
    - hold: counter increments, saturating.
    - legal change: counter reloads to 1.
  - prev<=T.
- Violations are evaluated on the current sample against prev and the counters:
  - code 1: illegal encoding on any lamp.
  - code 2: illegal transition, e.g. R->Y, G->R, Y->G.
  - code 3: number of non-red lamps > MAX_ACTIVE; fault_light=0 for this code.
  - code 4: Y->R with yellow counter < MIN_YELLOW.
  - code 5: green hold where the counter would reach MAX_GREEN.
- Fault priority: lowest code wins; within a code, the lowest lamp index wins.
- Fault timing:
  - The violating sample is taken at edge k.
  - At edge k the block enters FAULT, and fault=1, stop=1, code and light are registered.
  - All three are visible after edge k: one-cycle latency from the violating input, no combinational path to outputs.
- State FAULT:
  - stop=1, fault=1, armed=0.
  - Code, light and counters are frozen; new violations are ignored, so the first fault is kept.
  - clear=1 at an edge: fault, stop, fault_code and fault_light go to 0 and state goes to ARM.
  - A violation on the same edge as clear is not recorded; re-checking starts after re-arming.
- clear asserted outside FAULT is ignored.
- stop is asserted only in FAULT.
- Dwell counters saturate and never wrap. MAX_GREEN must be less than 2^CW; do not instantiate with MAX_GREEN >= 2^CW.
- At most one state transition per edge.

Test Plan:
- Reset held 10 ns, then all lamps 100 -> armed=1 after the first sample; no fault over 200 cycles with a legal sequence T1 R->G(10 cycles)->Y(3 cycles)->R.
- T3 driven 3'b011 while armed -> after the next edge fault=1, stop=1, fault_code=1, fault_light=2.
- T5 R->Y directly -> fault_code=2, fault_light=4. Then pulse clear with all lamps red -> fault=0, stop=0 next edge, armed=1 one edge later.
- T1, T2, T6 green simultaneously with MAX_ACTIVE=2 -> fault_code=3, fault_light=0.
- T4 G->Y, held Y 2 cycles, then R with MIN_YELLOW=3 -> fault_code=4, fault_light=3.
- T8 held green 40 samples -> fault_code=5, fault_light=7. Assert reset mid-FAULT -> all outputs 0 and state ARM on that edge.
- Simultaneous faults (T2 illegal encoding and T1 illegal transition in the same sample) -> fault_code=1, fault_light=1.

Source files
------------

// File: rtl/light_phase_monitor.sv
// Safety monitor for the traffic controller light bus: checks lamp encoding, colour
// order, concurrency and dwell times, latching the first fault and requesting a stop.
module light_phase_monitor #(
    parameter int CW         = 8,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_GREEN  = 40,
    parameter int MAX_ACTIVE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] T1,
    input  logic [2:0] T2,
    input  logic [2:0] T3,
    input  logic [2:0] T4,
    input  logic [2:0] T5,
    input  logic [2:0] T6,
    input  logic [2:0] T7,
    input  logic [2:0] T8,
    input  logic       clear,
    output logic       stop,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] fault_light,
    output logic       armed
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0][2:0]    lamp_p0;
    logic [7:0][2:0]    prev_p1;
    logic [7:0][CW-1:0] cnt_p1;

    logic [7:0] e_enc, e_trn, e_yel, e_grn;
    logic [3:0] nact;
    logic       all_legal;
    logic       viol;
    logic [2:0] vcode, vlight;

    function automatic logic legal(input logic [2:0] v);
        legal = (v == RED) || (v == YEL) || (v == GRN);
    endfunction

    function automatic logic legal_step(input logic [2:0] p, input logic [2:0] n);
        legal_step = ((p == RED) && (n == GRN)) ||
                     ((p == GRN) && (n == YEL)) ||
                     ((p == YEL) && (n == RED));
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        sat_inc = (c == {CW{1'b1}}) ? c : c + CW'(1);
    endfunction

    function automatic logic [2:0] first_idx(input logic [7:0] v);
        first_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) first_idx = 3'(i);
    endfunction

    assign lamp_p0 = {T8, T7, T6, T5, T4, T3, T2, T1};

    // Stage p0: classify the current sample against the registered history
    always_comb begin
        e_enc     = '0;
        e_trn     = '0;
        e_yel     = '0;
        e_grn     = '0;
        nact      = '0;
        all_legal = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!legal(lamp_p0[i])) begin
                e_enc[i]  = 1'b1;
                all_legal = 1'b0;
            end else begin
                if (lamp_p0[i] != RED) nact = nact + 4'd1;
                if ((lamp_p0[i] != prev_p1[i]) && !legal_step(prev_p1[i], lamp_p0[i]))
                    e_trn[i] = 1'b1;
                if ((prev_p1[i] == YEL) && (lamp_p0[i] == RED) && (cnt_p1[i] < CW'(MIN_YELLOW)))
                    e_yel[i] = 1'b1;
                if ((prev_p1[i] == GRN) && (lamp_p0[i] == GRN) &&
                    (sat_inc(cnt_p1[i]) >= CW'(MAX_GREEN)))
                    e_grn[i] = 1'b1;
            end
        end

        viol   = 1'b1;
        vcode  = 3'd0;
        vlight = 3'd0;
        if (|e_enc) begin
            vcode  = 3'd1;
            vlight = first_idx(e_enc);
        end else if (|e_trn) begin
            vcode  = 3'd2;
            vlight = first_idx(e_trn);
        end else if (nact > 4'(MAX_ACTIVE)) begin
            vcode  = 3'd3;
        end else if (|e_yel) begin
            vcode  = 3'd4;
            vlight = first_idx(e_yel);
        end else if (|e_grn) begin
            vcode  = 3'd5;
            vlight = first_idx(e_grn);
        end else begin
            viol   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_ARM;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stop      = 1'b0;
        fault     = 1'b0;
        armed     = 1'b0;
        case (state)
            ST_ARM: begin
                if (all_legal) state_nxt = ST_MONITOR;
            end
            ST_MONITOR: begin
                armed = 1'b1;
                if (viol) state_nxt = ST_FAULT;
            end
            ST_FAULT: begin
                stop  = 1'b1;
                fault = 1'b1;
                if (clear) state_nxt = ST_ARM;
            end
            default: state_nxt = ST_ARM;
        endcase
    end

    // Stage p1: lamp history, dwell counters and the latched fault record
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_p1     <= {8{RED}};
            cnt_p1      <= '0;
            fault_code  <= 3'd0;
            fault_light <= 3'd0;
        end else begin
            case (state)
                ST_ARM: begin
                    if (all_legal) begin
                        prev_p1 <= lamp_p0;
                        for (int i = 0; i < 8; i++) cnt_p1[i] <= CW'(1);
                    end
                end
                ST_MONITOR: begin
                    if (viol) begin
                        fault_code  <= vcode;
                        fault_light <= vlight;
                    end else begin
                        prev_p1 <= lamp_p0;
                        for (int i = 0; i < 8; i++)
                            cnt_p1[i] <= (lamp_p0[i] == prev_p1[i]) ? sat_inc(cnt_p1[i]) : CW'(1);
                    end
                end
                ST_FAULT: begin
                    if (clear) begin
                        fault_code  <= 3'd0;
                        fault_light <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_light_phase_monitor.sv
// Scoreboard bench for light_phase_monitor: expectations queued as stimulus is driven,
// compared against the observed {fault, stop, armed, fault_code, fault_light} per cycle.
module tb_light_phase_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [23:0] AR = {8{3'b100}};
    localparam logic [8:0] IDLE = 9'b000_000_000;
    localparam logic [8:0] MON  = 9'b001_000_000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [23:0] lamps = {8{3'b100}};
    logic        stop, fault, armed;
    logic [2:0]  fault_code, fault_light;

    logic [8:0] expq[$];
    logic [8:0] obsq[$];
    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    light_phase_monitor #(.CW(8), .MIN_YELLOW(3), .MAX_GREEN(40), .MAX_ACTIVE(2)) dut (
        .clk(clk), .reset(reset),
        .T1(lamps[2:0]),   .T2(lamps[5:3]),   .T3(lamps[8:6]),   .T4(lamps[11:9]),
        .T5(lamps[14:12]), .T6(lamps[17:15]), .T7(lamps[20:18]), .T8(lamps[23:21]),
        .clear(clear), .stop(stop), .fault(fault), .fault_code(fault_code),
        .fault_light(fault_light), .armed(armed)
    );

    function automatic logic [8:0] flt(input logic [2:0] code, input logic [2:0] light);
        flt = {2'b11, 1'b0, code, light};
    endfunction

    function automatic logic [23:0] put(input logic [23:0] b, input int k, input logic [2:0] v);
        put = b;
        put[k*3 +: 3] = v;
    endfunction

    task automatic step(input logic [23:0] l, input logic clr, input logic rst, input logic [8:0] e);
        lamps = l;
        clear = clr;
        reset = rst;
        expq.push_back(e);
        @(posedge clk);
        #1;
        obsq.push_back({fault, stop, armed, fault_code, fault_light});
        clear = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] e, o;
        int n = 0;
        step(AR, 1'b0, 1'b1, IDLE);
        step(put(AR, 0, 3'b111), 1'b0, 1'b1, IDLE);
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL test_reset step %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_legal_sequence();
        logic [8:0] e, o;
        int n = 0;
        int p;
        step(AR, 1'b0, 1'b0, MON);
        for (int i = 0; i < 200; i++) begin
            p = i % 20;
            step(put(AR, 0, (p < 10) ? G : (p < 13) ? Y : R), (i == 50), 1'b0, MON);
        end
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL test_legal_sequence step %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_illegal_encoding();
        logic [8:0] e, o;
        int n = 0;
        step(put(AR, 2, 3'b011), 1'b0, 1'b0, flt(3'd1, 3'd2));
        step(put(AR, 4, Y), 1'b0, 1'b0, flt(3'd1, 3'd2));
        step(AR, 1'b0, 1'b0, flt(3'd1, 3'd2));
        step(AR, 1'b0, 1'b1, IDLE);
        step(AR, 1'b0, 1'b0, MON);
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL test_illegal_encoding step %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_transition_clear();
        logic [8:0] e, o;
        int n = 0;
        step(put(AR, 4, Y), 1'b0, 1'b0, flt(3'd2, 3'd4));
        step(AR, 1'b1, 1'b0, IDLE);
        step(AR, 1'b0, 1'b0, MON);
        step(put(AR, 1, Y), 1'b0, 1'b0, flt(3'd2, 3'd1));
        step(put(AR, 0, 3'b000), 1'b1, 1'b0, IDLE);
        step(AR, 1'b0, 1'b0, MON);
        step(AR, 1'b0, 1'b0, MON);
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL test_transition_clear step %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_concurrency();
        logic [8:0] e, o;
        int n = 0;
        logic [23:0] two;
        two = put(put(AR, 0, G), 1, G);
        step(two, 1'b0, 1'b0, MON);
        step(put(two, 5, G), 1'b0, 1'b0, flt(3'd3, 3'd0));
        step(AR, 1'b0, 1'b1, IDLE);
        step(AR, 1'b0, 1'b0, MON);
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL test_concurrency step %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_min_yellow();
        logic [8:0] e, o;
        int n = 0;
        step(put(AR, 3, G), 1'b0, 1'b0, MON);
        step(put(AR, 3, G), 1'b0, 1'b0, MON);
        step(put(AR, 3, Y), 1'b0, 1'b0, MON);
        step(put(AR, 3, Y), 1'b0, 1'b0, MON);
        step(AR, 1'b0, 1'b0, flt(3'd4, 3'd3));
        step(AR, 1'b0, 1'b1, IDLE);
        step(AR, 1'b0, 1'b0, MON);
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL test_min_yellow step %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_green_timeout();
        logic [8:0] e, o;
        int n = 0;
        for (int i = 1; i < 40; i++) step(put(AR, 7, G), 1'b0, 1'b0, MON);
        step(put(AR, 7, G), 1'b0, 1'b0, flt(3'd5, 3'd7));
        step(put(AR, 7, Y), 1'b0, 1'b0, flt(3'd5, 3'd7));
        step(put(AR, 7, 3'b111), 1'b0, 1'b1, IDLE);
        step(AR, 1'b0, 1'b0, MON);
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL test_green_timeout step %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_simultaneous();
        logic [8:0] e, o;
        int n = 0;
        step(put(put(AR, 0, Y), 1, 3'b110), 1'b0, 1'b0, flt(3'd1, 3'd1));
        step(AR, 1'b0, 1'b1, IDLE);
        step(AR, 1'b0, 1'b0, MON);
        while (expq.size() > 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); tests++;
            if (o !== e) begin
                failed++;
                $display("FAIL test_simultaneous step %0d: got %b expected %b", n, o, e);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_legal_sequence();
        test_illegal_encoding();
        test_transition_clear();
        test_concurrency();
        test_min_yellow();
        test_green_timeout();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
